// File: rtl/bpu.sv
// Direct-mapped branch predictor: tagged entries with 2-bit direction counters and taken targets.
// Lookups are registered one cycle; BRU updates train or allocate the entry at the branch's index.
module bpu #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_valid,
  input  logic [31:0] i_fetch_pc,
  input  logic        i_bru_valid,
  input  logic [31:0] i_bru_pc,
  input  logic        i_bru_taken,
  input  logic [31:0] i_bru_target,
  output logic        o_prd_valid,
  output logic [31:0] o_prd_pc,
  output logic        o_prd_hit,
  output logic        o_prd_taken,
  output logic [31:0] o_prd_target
);

  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic             f_taken;
  logic [31:0]      f_target;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;

  // Instruction-alignment bits never take part in index or tag.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_fetch_pc[1:0], i_bru_pc[1:0]};

  // Lookup and update decode against the pre-update table contents.
  always_comb begin
    f_idx    = i_fetch_pc[IDX_W+1:2];
    f_tag    = i_fetch_pc[31:IDX_W+2];
    f_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    f_taken  = f_hit && ctr_q[f_idx][1];
    f_target = f_taken ? target_q[f_idx] : (i_fetch_pc + 32'd4);
    u_idx    = i_bru_pc[IDX_W+1:2];
    u_tag    = i_bru_pc[31:IDX_W+2];
    u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  end

  // Table training: hits adjust the counter, taken misses allocate, not-taken misses are dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (i_bru_valid) begin
      if (u_hit) begin
        if (i_bru_taken) begin
          if (ctr_q[u_idx] != 2'b11) ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
          target_q[u_idx] <= i_bru_target;
        end else if (ctr_q[u_idx] != 2'b00) begin
          ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
        end
      end else if (i_bru_taken) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= i_bru_target;
        ctr_q[u_idx]    <= 2'b10;
      end
    end
  end

  // Prediction register; payload holds its last value when no lookup is issued.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_prd_valid  <= 1'b0;
      o_prd_pc     <= '0;
      o_prd_hit    <= 1'b0;
      o_prd_taken  <= 1'b0;
      o_prd_target <= '0;
    end else begin
      o_prd_valid <= i_fetch_valid;
      if (i_fetch_valid) begin
        o_prd_pc     <= i_fetch_pc;
        o_prd_hit    <= f_hit;
        o_prd_taken  <= f_taken;
        o_prd_target <= f_target;
      end
    end
  end

endmodule

// File: doc/bpu.md
BPU -- requirements
Module: bpu

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of direct-mapped predictor entries (power of two, >= 2).
REQ-002 SHALL have parameter IDX_W, default 4, equal to log2(ENTRIES); index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2].
REQ-003 SHALL have i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have i_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have i_fetch_valid  input  1  fetch-side lookup request this cycle.
REQ-006 SHALL have i_fetch_pc  input  32  PC of the instruction being looked up.
REQ-007 SHALL have i_bru_valid  input  1  resolved conditional branch from BRU this cycle.
REQ-008 SHALL have i_bru_pc  input  32  PC of the resolved branch.
REQ-009 SHALL have i_bru_taken  input  1  resolved direction from BRU (branch_s.taken).
REQ-010 SHALL have i_bru_target  input  32  resolved taken target.
REQ-011 SHALL have o_prd_valid  output  1  prediction valid, one cycle after i_fetch_valid.
REQ-012 SHALL have o_prd_pc  output  32  registered copy of the looked-up PC.
REQ-013 SHALL have o_prd_hit  output  1  lookup matched a valid entry tag.
REQ-014 SHALL have o_prd_taken  output  1  predicted direction.
REQ-015 SHALL have o_prd_target  output  32  predicted next PC.

Function
REQ-016 SHALL hold per entry: valid bit, tag (32-IDX_W-2 bits), 32-bit target, 2-bit saturating counter ctr.
REQ-017 SHALL register a lookup: on an edge with i_fetch_valid=1, o_prd_valid=1 and o_prd_pc=i_fetch_pc next cycle; otherwise o_prd_valid=0 next cycle, other outputs don't-care but held.
REQ-018 SHALL set hit = entry[idx].valid and entry[idx].tag == tag(i_fetch_pc).
REQ-019 SHALL predict taken = hit and ctr[1]; target = entry target when taken, else i_fetch_pc+4 (modulo 2^32).
REQ-020 SHALL, on i_bru_valid with tag hit: ctr increments when taken (saturate at 11), decrements when not taken (saturate at 00); target overwritten with i_bru_target only when taken.
REQ-021 SHALL, on i_bru_valid with miss and taken: allocate/replace entry[idx]: valid=1, new tag, target=i_bru_target, ctr=10.
REQ-022 SHALL, on i_bru_valid with miss and not taken: leave the table unchanged.
REQ-023 SHALL, with lookup and update to the same index in one cycle, return the pre-update entry (no bypass); update visible from the next cycle's lookup.
REQ-024 SHALL perform at most one update per cycle; no stall/ready signals, accepts every valid request.

Reset
REQ-025 SHALL, on i_rst=1 at an edge: all entries valid=0, ctr=01, tags/targets 0; o_prd_valid=0, o_prd_hit=0, o_prd_taken=0, o_prd_pc=0, o_prd_target=0.
REQ-026 SHALL give reset priority over simultaneous fetch and update; both ignored in that cycle.
REQ-027 SHALL discard all training on reset mid-operation; first post-reset lookup misses.

Verification
REQ-028 After reset, fetch 0x100 -> next cycle prd_valid=1, hit=0, taken=0, target=0x104.
REQ-029 Update pc 0x100 taken target 0x200, then fetch 0x100 -> hit=1, taken=1, target=0x200; one not-taken update (ctr 10->01) -> taken=0, target=0x104, hit=1.
REQ-030 Four taken updates to 0x100 (ctr saturates 11), one not-taken -> still taken=1, target=0x200.
REQ-031 Train 0x100 taken, then taken update 0x140 target 0x300 (same index 0) -> fetch 0x140 gives 0x300 taken; fetch 0x100 gives hit=0, target=0x104; not-taken update to untrained 0x180 -> no allocation.
REQ-032 Same-cycle fetch 0x100 and first taken update 0x100 -> that prediction taken=0, target=0x104; fetch next cycle -> taken=1, target=0x200.
REQ-033 Train 0x100, assert i_rst one cycle with i_fetch_valid=1 -> next cycle prd_valid=0; fetch 0x100 afterwards -> hit=0, taken=0.
